// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle control unit in front of the ALU.
// Fetches an instruction over a ready handshake, decodes the opcode, holds
// MULT/DIV for MULDIV_CICLOS execute cycles, samples the ALU branch flag and
// issues register-write / PC-update strobes.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   instrucao_i[31:0]          instruction word; only [31:26] is used here
//   mem_pronta_i               instruction memory has valid data
//   sinal_desvio_i             branch-taken flag from the ALU
//   le_memoria_o               fetch request (high in BUSCA)
//   carrega_ir_o               one-cycle strobe: IR now holds a new word
//   modo_funcao_uc_o[5:0]      ALU function code
//   sel_imediato_o             ALU operand B = immediate (ADDI/SUBI)
//   escreve_reg_o              register-file write strobe
//   incrementa_pc_o            PC+1 strobe
//   carrega_pc_desvio_o        PC<=target strobe
//   halt_o                     sticky stop indicator
//   erro_opcode_o              undefined-opcode pulse
//   estado_o[2:0]              current state, for debug
//   instrucoes_executadas_o    retired-instruction counter (wraps)
module unidade_controle #(
  parameter int unsigned MULDIV_CICLOS = 4,
  parameter int unsigned CONT_LARGURA  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             instrucao_i,
  input  logic                    mem_pronta_i,
  input  logic                    sinal_desvio_i,
  output logic                    le_memoria_o,
  output logic                    carrega_ir_o,
  output logic [5:0]              modo_funcao_uc_o,
  output logic                    sel_imediato_o,
  output logic                    escreve_reg_o,
  output logic                    incrementa_pc_o,
  output logic                    carrega_pc_desvio_o,
  output logic                    halt_o,
  output logic                    erro_opcode_o,
  output logic [2:0]              estado_o,
  output logic [CONT_LARGURA-1:0] instrucoes_executadas_o
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MULDIV_CARGA = CNT_W'(MULDIV_CICLOS - 1);
  localparam logic [5:0] MODO_OCIOSO = 6'b111110;

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    ESCRITA    = 3'd3,
    DESVIO     = 3'd4,
    PARADO     = 3'd5
  } estado_e;

  typedef enum logic [2:0] {
    C_ALU, C_BR, C_JMP, C_NOP, C_HALT, C_UNDEF
  } classe_e;

  // Opcode class decode
  function automatic classe_e classifica(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100,
      6'b000101, 6'b000110, 6'b000111, 6'b001000, 6'b001001,
      6'b010000, 6'b010001:                         return C_ALU;
      6'b001010, 6'b001011, 6'b001100, 6'b001101: return C_BR;
      6'b001110:                                    return C_JMP;
      6'b111110:                                    return C_NOP;
      6'b111111:                                    return C_HALT;
      default:                                      return C_UNDEF;
    endcase
  endfunction

  estado_e                 state_q, state_d;
  logic [5:0]              ir_q, ir_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    flag_q, flag_d;
  logic [CONT_LARGURA-1:0] count_q, count_d;
  classe_e                 classe_q, classe_d;
  logic                    retire_c;
  logic                    grupo_exec_c, tomado_c;

  logic       le_q, le_d;
  logic       cir_q, cir_d;
  logic [5:0] modo_q, modo_d;
  logic       sel_q, sel_d;
  logic       esc_q, esc_d;
  logic       inc_q, inc_d;
  logic       cpc_q, cpc_d;
  logic       halt_q, halt_d;
  logic       erro_q, erro_d;

  // Only the opcode field is used by this block
  logic unused_campos;
  assign unused_campos = ^instrucao_i[25:0];

  assign classe_q = classifica(ir_q);

  // Next state plus next value of every registered output
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    flag_d   = flag_q;
    retire_c = 1'b0;

    case (state_q)
      BUSCA: begin
        if (mem_pronta_i) begin
          ir_d    = instrucao_i[31:26];
          state_d = DECODIFICA;
        end
      end
      DECODIFICA: begin
        case (classe_q)
          C_ALU, C_BR: begin
            state_d = EXECUTA;
            cnt_d   = (ir_q == 6'b000010 || ir_q == 6'b000011) ? MULDIV_CARGA : '0;
          end
          C_JMP:   state_d = DESVIO;
          C_HALT:  state_d = PARADO;
          default: begin
            retire_c = 1'b1;
            state_d  = BUSCA;
          end
        endcase
      end
      EXECUTA: begin
        if (cnt_q != '0) begin
          cnt_d = CNT_W'(cnt_q - 1'b1);
        end else if (classe_q == C_BR) begin
          flag_d  = sinal_desvio_i;
          state_d = DESVIO;
        end else begin
          state_d = ESCRITA;
        end
      end
      ESCRITA, DESVIO: begin
        retire_c = 1'b1;
        state_d  = BUSCA;
      end
      PARADO:  state_d = PARADO;
      default: state_d = BUSCA;
    endcase

    classe_d = classifica(ir_d);
    count_d  = retire_c ? CONT_LARGURA'(count_q + 1'b1) : count_q;

    // Outputs reflect the state being entered, so they line up with it
    grupo_exec_c = (state_d == EXECUTA) || (state_d == ESCRITA) || (state_d == DESVIO);
    tomado_c     = (classe_d == C_JMP) || flag_d;

    le_d   = (state_d == BUSCA);
    cir_d  = (state_d == DECODIFICA);
    modo_d = grupo_exec_c ? ir_d : MODO_OCIOSO;
    sel_d  = grupo_exec_c && (ir_d == 6'b010000 || ir_d == 6'b010001);
    esc_d  = (state_d == ESCRITA);
    inc_d  = (state_d == ESCRITA)
          || ((state_d == DECODIFICA) && (classe_d == C_NOP || classe_d == C_UNDEF))
          || ((state_d == DESVIO) && !tomado_c);
    cpc_d  = (state_d == DESVIO) && tomado_c;
    halt_d = (state_d == PARADO);
    erro_d = (state_d == DECODIFICA) && (classe_d == C_UNDEF);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUSCA;
      ir_q    <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      count_q <= '0;
      le_q    <= 1'b1;
      cir_q   <= 1'b0;
      modo_q  <= MODO_OCIOSO;
      sel_q   <= 1'b0;
      esc_q   <= 1'b0;
      inc_q   <= 1'b0;
      cpc_q   <= 1'b0;
      halt_q  <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      count_q <= count_d;
      le_q    <= le_d;
      cir_q   <= cir_d;
      modo_q  <= modo_d;
      sel_q   <= sel_d;
      esc_q   <= esc_d;
      inc_q   <= inc_d;
      cpc_q   <= cpc_d;
      halt_q  <= halt_d;
      erro_q  <= erro_d;
    end
  end

  assign le_memoria_o            = le_q;
  assign carrega_ir_o            = cir_q;
  assign modo_funcao_uc_o        = modo_q;
  assign sel_imediato_o          = sel_q;
  assign escreve_reg_o           = esc_q;
  assign incrementa_pc_o         = inc_q;
  assign carrega_pc_desvio_o     = cpc_q;
  assign halt_o                  = halt_q;
  assign erro_opcode_o           = erro_q;
  assign estado_o                = state_q;
  assign instrucoes_executadas_o = count_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: directed and random instructions
// compared cycle by cycle against a trace model derived from the opcode rules.
module tb_unidade_controle;

  localparam int unsigned MULDIV = 4;
  localparam int unsigned CW     = 4;

  localparam int S_BUSCA = 0, S_DEC = 1, S_EX = 2, S_ESC = 3, S_DES = 4, S_PAR = 5;
  localparam int K_ALU = 0, K_BR = 1, K_JMP = 2, K_NOP = 3, K_HALT = 4, K_UNDEF = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   instrucao = '0;
  logic          mem_pronta = 1'b0;
  logic          sinal_desvio = 1'b0;
  logic          le_memoria, carrega_ir, sel_imediato, escreve_reg;
  logic          incrementa_pc, carrega_pc_desvio, halt, erro_opcode;
  logic [5:0]    modo;
  logic [2:0]    estado;
  logic [CW-1:0] contagem;

  int tests = 0;
  int fails = 0;
  int model_count = 0;

  unidade_controle #(.MULDIV_CICLOS(MULDIV), .CONT_LARGURA(CW)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .instrucao_i             (instrucao),
    .mem_pronta_i            (mem_pronta),
    .sinal_desvio_i          (sinal_desvio),
    .le_memoria_o            (le_memoria),
    .carrega_ir_o            (carrega_ir),
    .modo_funcao_uc_o        (modo),
    .sel_imediato_o          (sel_imediato),
    .escreve_reg_o           (escreve_reg),
    .incrementa_pc_o         (incrementa_pc),
    .carrega_pc_desvio_o     (carrega_pc_desvio),
    .halt_o                  (halt),
    .erro_opcode_o           (erro_opcode),
    .estado_o                (estado),
    .instrucoes_executadas_o (contagem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int classe(input logic [5:0] op);
    if (op <= 6'd9 || op == 6'd16 || op == 6'd17) return K_ALU;
    if (op >= 6'd10 && op <= 6'd13) return K_BR;
    if (op == 6'd14) return K_JMP;
    if (op == 6'd62) return K_NOP;
    if (op == 6'd63) return K_HALT;
    return K_UNDEF;
  endfunction

  // Expected outputs for one cycle spent in state s
  task automatic check_cycle(input int s, input logic [5:0] op, input int k, input logic tomado);
    logic ex_grp;
    ex_grp = (s == S_EX || s == S_ESC || s == S_DES);
    chk("estado", 32'(estado), 32'(s));
    chk("le_memoria", 32'(le_memoria), 32'(s == S_BUSCA));
    chk("carrega_ir", 32'(carrega_ir), 32'(s == S_DEC));
    chk("modo", 32'(modo), ex_grp ? 32'(op) : 32'h3E);
    chk("sel_imediato", 32'(sel_imediato), 32'(ex_grp && (op == 6'd16 || op == 6'd17)));
    chk("escreve_reg", 32'(escreve_reg), 32'(s == S_ESC));
    chk("incrementa_pc", 32'(incrementa_pc),
        32'(s == S_ESC || (s == S_DEC && (k == K_NOP || k == K_UNDEF)) || (s == S_DES && !tomado)));
    chk("carrega_pc_desvio", 32'(carrega_pc_desvio), 32'(s == S_DES && tomado));
    chk("erro_opcode", 32'(erro_opcode), 32'(s == S_DEC && k == K_UNDEF));
    chk("halt", 32'(halt), 32'(s == S_PAR));
    chk("contagem", 32'(contagem), 32'(model_count));
  endtask

  // Runs one instruction from a BUSCA negedge to the next BUSCA negedge
  task automatic run_instr(input logic [31:0] instr, input int espera, input logic desvio);
    int seq[$];
    logic [5:0] op;
    int k, s, n;
    logic tomado;
    op = instr[31:26];
    k  = classe(op);
    tomado = (k == K_JMP) || (k == K_BR && desvio);
    for (int i = 0; i <= espera; i++) seq.push_back(S_BUSCA);
    seq.push_back(S_DEC);
    if (k == K_ALU) begin
      n = (op == 6'd2 || op == 6'd3) ? int'(MULDIV) : 1;
      for (int i = 0; i < n; i++) seq.push_back(S_EX);
      seq.push_back(S_ESC);
    end else if (k == K_BR) begin
      seq.push_back(S_EX);
      seq.push_back(S_DES);
    end else if (k == K_JMP) begin
      seq.push_back(S_DES);
    end else if (k == K_HALT) begin
      for (int i = 0; i < 21; i++) seq.push_back(S_PAR);
    end
    for (int i = 0; i < seq.size(); i++) begin
      s = seq[i];
      check_cycle(s, op, k, tomado);
      if (s == S_BUSCA) begin
        mem_pronta = (i == espera);
        instrucao  = (i == espera) ? instr : $urandom;
      end else begin
        mem_pronta = 1'($urandom_range(0, 1));
        instrucao  = $urandom;
      end
      if (s == S_EX && i + 1 < seq.size() && seq[i+1] != S_EX) sinal_desvio = desvio;
      else sinal_desvio = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      if ((s == S_DEC && (k == K_NOP || k == K_UNDEF)) || s == S_ESC || s == S_DES)
        model_count = (model_count + 1) % (1 << CW);
    end
    mem_pronta = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_pronta = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_count = 0;
  endtask

  initial begin
    logic [5:0] op;
    // Reset values while held in reset
    @(negedge clk);
    @(negedge clk);
    chk("rst_estado", 32'(estado), 32'(S_BUSCA));
    chk("rst_contagem", 32'(contagem), 32'd0);
    chk("rst_modo", 32'(modo), 32'h3E);
    chk("rst_strobes", {26'd0, carrega_ir, escreve_reg, incrementa_pc, carrega_pc_desvio, halt, erro_opcode}, 32'd0);
    chk("rst_sel", 32'(sel_imediato), 32'd0);
    rst_n = 1'b1;

    run_instr(32'h0000_0000, 0, 1'b0);     // ADD
    chk("add_retired", 32'(contagem), 32'd1);
    run_instr(32'h0800_0000, 0, 1'b0);     // MULT
    run_instr(32'h4000_0005, 0, 1'b0);     // ADDI
    run_instr(32'h2800_0000, 0, 1'b1);     // BEQ taken
    run_instr(32'h2800_0000, 0, 1'b0);     // BEQ not taken
    run_instr(32'h3800_0000, 0, 1'b0);     // JMP
    run_instr(32'h0000_0000, 5, 1'b0);     // fetch stall
    run_instr(32'hA800_0000, 0, 1'b0);     // undefined 101010

    for (int n = 0; n < 40; n++) begin
      op = 6'($urandom_range(0, 62));
      run_instr({op, 26'($urandom)}, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a DIV
    run_instr(32'h0000_0000, 0, 1'b0);
    instrucao  = 32'h0C00_0000;
    mem_pronta = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_pronta = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("div_in_exec", 32'(estado), 32'(S_EX));
    rst_n = 1'b0;
    #1;
    chk("div_rst_estado", 32'(estado), 32'(S_BUSCA));
    chk("div_rst_contagem", 32'(contagem), 32'd0);
    chk("div_rst_escreve", 32'(escreve_reg), 32'd0);
    @(negedge clk);
    chk("div_rst_no_write", 32'(escreve_reg), 32'd0);
    rst_n = 1'b1;
    model_count = 0;

    // Counter wrap at CW bits
    for (int n = 0; n < 16; n++) run_instr(32'hF800_0000, 0, 1'b0);
    chk("wrap_zero", 32'(contagem), 32'd0);
    run_instr(32'h0400_0000, 0, 1'b0);

    // HALT is sticky and does not retire
    run_instr(32'hFC00_0000, 0, 1'b0);
    chk("halt_sticky", 32'(halt), 32'd1);
    do_reset();
    chk("halt_cleared", 32'(halt), 32'd0);
    run_instr(32'h4400_0001, 1, 1'b0);     // SUBI after recovery

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
